pipe_trace_buffer: RTL and testbench

PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

---
 rtl/pipe_trace_buffer.sv | 144 ++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace buffer: records per-stage PC/instruction snapshots around
// a trigger event, then streams them out oldest first.
module pipe_trace_buffer #(
    parameter int STAGES     = 5,
    parameter int PC_W       = 32,
    parameter int INSTR_W    = 32,
    parameter int DEPTH      = 64,
    parameter int SKIP_STALL = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [STAGES*PC_W-1:0]        stage_pc,
    input  logic [STAGES*INSTR_W-1:0]     stage_instr,
    input  logic                          stall,
    input  logic                          arm,
    input  logic                          clear,
    input  logic [1:0]                    trig_mode,
    input  logic [$clog2(STAGES)-1:0]     trig_stage,
    input  logic [PC_W-1:0]               trig_pc,
    input  logic [$clog2(DEPTH)-1:0]      post_count,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [1+STAGES*(PC_W+INSTR_W)-1:0] rd_data,
    output logic                          rd_last,
    output logic [1:0]                    status
);

    localparam int ENTRY_W = 1 + STAGES*(PC_W+INSTR_W);
    localparam int AW      = $clog2(DEPTH);
    localparam int SW      = $clog2(STAGES);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        POST    = 2'b10,
        READOUT = 2'b11
    } state_t;

    state_t state, state_nx;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr, post_cnt, post_q;
    logic [AW:0]        fill, rd_rem;
    logic [1:0]         mode_q;
    logic [SW-1:0]      tstage_q;
    logic [PC_W-1:0]    tpc_q;
    logic               prev_stall;
    logic               stage_hit, any_hit, trig, capt, rec;
    logic [AW-1:0]      wr_nx;
    logic [AW:0]        fill_nx;

    always_comb begin
        stage_hit = 1'b0;
        any_hit   = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (stage_pc[i*PC_W +: PC_W] == tpc_q) begin
                any_hit = 1'b1;
                if (int'(tstage_q) == i) stage_hit = 1'b1;
            end
        end
    end

    always_comb begin
        unique case (mode_q)
            2'b00:   trig = 1'b1;
            2'b01:   trig = stage_hit;
            2'b10:   trig = stall & ~prev_stall;
            default: trig = any_hit;
        endcase
    end

    // the trigger cycle is always recorded, even when stalls are skipped
    assign capt = (SKIP_STALL == 0) || !stall;
    assign rec  = ((state == ARMED) && (capt || trig))
               || ((state == POST) && capt);

    assign wr_nx   = wr_ptr + AW'(1);
    assign fill_nx = (fill == (AW+1)'(DEPTH)) ? fill : fill + (AW+1)'(1);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (arm) state_nx = ARMED;
            ARMED:   if (trig) state_nx = (post_q == '0) ? READOUT : POST;
            POST:    if (rec && post_cnt == AW'(1)) state_nx = READOUT;
            READOUT: if (rd_ready && rd_rem == (AW+1)'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            rd_rem     <= '0;
            post_cnt   <= '0;
            post_q     <= '0;
            mode_q     <= '0;
            tstage_q   <= '0;
            tpc_q      <= '0;
            prev_stall <= 1'b0;
        end else begin
            state      <= state_nx;
            prev_stall <= stall;
            if (state == IDLE && arm) begin
                wr_ptr     <= '0;
                fill       <= '0;
                prev_stall <= 1'b0;
                mode_q     <= trig_mode;
                tstage_q   <= trig_stage;
                tpc_q      <= trig_pc;
                post_q     <= post_count;
            end
            if (rec) begin
                wr_ptr <= wr_nx;
                fill   <= fill_nx;
            end
            if (state == POST && rec) post_cnt <= post_cnt - AW'(1);
            if (state == ARMED && trig) post_cnt <= post_q;
            // entry into readout always coincides with a recorded entry
            if (state != READOUT && state_nx == READOUT) begin
                rd_ptr <= wr_nx - fill_nx[AW-1:0];
                rd_rem <= fill_nx;
            end
            if (state == READOUT && rd_ready) begin
                rd_ptr <= rd_ptr + AW'(1);
                rd_rem <= rd_rem - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rec) mem[wr_ptr] <= {stall, stage_pc, stage_instr};
    end

    assign status   = state;
    assign rd_valid = (state == READOUT);
    assign rd_last  = rd_valid && (rd_rem == (AW+1)'(1));
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: triggers, wrap, stall skipping,
// readout back-pressure, reset and clear.
module tb_pipe_trace_buffer;

    localparam int STAGES  = 5;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 64;
    localparam int EW      = 1 + STAGES*(PC_W+INSTR_W);
    localparam int PCB     = STAGES*INSTR_W;

    logic clk = 1'b0;
    logic reset;
    logic [STAGES*PC_W-1:0]    stage_pc;
    logic [STAGES*INSTR_W-1:0] stage_instr;
    logic stall, arm, clear, rd_ready;
    logic [1:0]  trig_mode;
    logic [2:0]  trig_stage;
    logic [31:0] trig_pc;
    logic [5:0]  post_count;

    logic          a_valid, a_last, b_valid, b_last;
    logic [EW-1:0] a_data, b_data;
    logic [1:0]    a_status, b_status;

    int vectors = 0;
    int miscompares = 0;
    bit sel = 1'b0;
    logic [31:0] pcf;
    logic [EW-1:0] got_q[$];
    bit last_q[$];
    int exp_j[6] = '{1, 2, 3, 5, 6, 8};

    wire          m_valid  = sel ? b_valid : a_valid;
    wire          m_last   = sel ? b_last : a_last;
    wire [EW-1:0] m_data   = sel ? b_data : a_data;
    wire [1:0]    m_status = sel ? b_status : a_status;

    always #5 clk = ~clk;

    pipe_trace_buffer dut (
        .clk(clk), .reset(reset),
        .stage_pc(stage_pc), .stage_instr(stage_instr),
        .stall(stall), .arm(arm), .clear(clear),
        .trig_mode(trig_mode), .trig_stage(trig_stage),
        .trig_pc(trig_pc), .post_count(post_count),
        .rd_valid(a_valid), .rd_ready(rd_ready),
        .rd_data(a_data), .rd_last(a_last), .status(a_status)
    );

    pipe_trace_buffer #(.SKIP_STALL(1)) dut_s (
        .clk(clk), .reset(reset),
        .stage_pc(stage_pc), .stage_instr(stage_instr),
        .stall(stall), .arm(arm), .clear(clear),
        .trig_mode(trig_mode), .trig_stage(trig_stage),
        .trig_pc(trig_pc), .post_count(post_count),
        .rd_valid(b_valid), .rd_ready(rd_ready),
        .rd_data(b_data), .rd_last(b_last), .status(b_status)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fpc(input logic [EW-1:0] e, input int s);
        return e[PCB + s*PC_W +: PC_W];
    endfunction

    task automatic repack();
        for (int i = 0; i < STAGES; i++) begin
            stage_pc[i*PC_W +: PC_W]       = pcf - 32'(4*i);
            stage_instr[i*INSTR_W +: INSTR_W] = ~(pcf - 32'(4*i));
        end
    endtask

    task automatic set_pc(input logic [31:0] v);
        pcf = v;
        repack();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pcf = pcf + 32'd4;
        repack();
    endtask

    task automatic start(input logic [1:0] m, input logic [2:0] s,
                         input logic [31:0] p, input logic [5:0] n,
                         input logic [31:0] a);
        clear = 1'b1;
        step();
        clear = 1'b0;
        set_pc(a);
        trig_mode = m;
        trig_stage = s;
        trig_pc = p;
        post_count = n;
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("armed", 64'(m_status), 64'd1);
    endtask

    task automatic drain(input bit toggle, input int budget);
        logic [EW-1:0] held;
        bit hold, done;
        got_q.delete();
        last_q.delete();
        hold = 1'b0;
        done = 1'b0;
        held = '0;
        for (int k = 0; k < budget && !done; k++) begin
            if (hold) begin
                chk("stable_lo", m_data[63:0], held[63:0]);
                chk("stable_pc", 64'(fpc(m_data, 0)), 64'(fpc(held, 0)));
            end
            hold = 1'b0;
            rd_ready = toggle ? (k % 2 == 1) : 1'b1;
            if (m_valid) begin
                if (rd_ready) begin
                    got_q.push_back(m_data);
                    last_q.push_back(m_last);
                    done = m_last;
                end else begin
                    hold = 1'b1;
                    held = m_data;
                end
            end
            step();
        end
        rd_ready = 1'b0;
        chk("drain_done", 64'(done), 64'd1);
        chk("post_idle", 64'(m_status), 64'd0);
        chk("post_valid", 64'(m_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        arm = 1'b0;
        clear = 1'b0;
        stall = 1'b0;
        rd_ready = 1'b0;
        trig_mode = '0;
        trig_stage = '0;
        trig_pc = '0;
        post_count = '0;
        set_pc(32'h1000);
        #12;
        chk("rst_status", 64'(a_status), 64'd0);
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_last", 64'(a_last), 64'd0);
        chk("rst_data", 64'(|a_data), 64'd0);
        reset = 1'b1;
        step();
        step();
        chk("idle_hold", 64'(a_status), 64'd0);

        // immediate trigger, 3 post entries, stray arm during POST
        start(2'b00, 3'd0, 32'h0, 6'd3, 32'h1000);
        step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        step();
        chk("t1_readout", 64'(a_status), 64'd3);
        drain(1'b0, 20);
        chk("t1_count", 64'(got_q.size()), 64'd4);
        for (int k = 0; k < got_q.size(); k++)
            chk("t1_pc", 64'(fpc(got_q[k], 0)), 64'(32'h1000 + 32'(4*(k+1))));
        if (got_q.size() == 4) begin
            chk("t1_last0", 64'(last_q[0]), 64'd0);
            chk("t1_last3", 64'(last_q[3]), 64'd1);
        end

        // stage-2 PC match after 100 armed cycles, buffer wraps
        start(2'b01, 3'd2, 32'h3010, 6'd8, 32'h2E84);
        trig_mode = 2'b00;
        trig_pc = '0;
        trig_stage = '0;
        post_count = '0;
        repeat (100) step();
        chk("t2_armed", 64'(a_status), 64'd1);
        step();
        chk("t2_post", 64'(a_status), 64'd2);
        repeat (8) step();
        chk("t2_readout", 64'(a_status), 64'd3);
        drain(1'b0, 80);
        chk("t2_count", 64'(got_q.size()), 64'd64);
        if (got_q.size() == 64) begin
            chk("t2_trig_epc", 64'(fpc(got_q[55], 2)), 64'h3010);
            chk("t2_first", 64'(fpc(got_q[0], 0)), 64'h2F3C);
            chk("t2_final", 64'(fpc(got_q[63], 0)), 64'h3038);
            chk("t2_last", 64'(last_q[63]), 64'd1);
        end

        // stall skipping; trigger lands on a stalled cycle
        sel = 1'b1;
        start(2'b00, 3'd0, 32'h0, 6'd5, 32'h5000);
        for (int j = 1; j <= 8; j++) begin
            stall = (j % 3 == 1);
            step();
        end
        stall = 1'b0;
        chk("t3_readout", 64'(b_status), 64'd3);
        drain(1'b0, 20);
        chk("t3_count", 64'(got_q.size()), 64'd6);
        for (int k = 0; k < got_q.size() && k < 6; k++) begin
            chk("t3_pc", 64'(fpc(got_q[k], 0)), 64'(32'h5000 + 32'(4*exp_j[k])));
            chk("t3_stall", 64'(got_q[k][EW-1]), (k == 0) ? 64'd1 : 64'd0);
        end
        sel = 1'b0;

        // stall rising edge, post_count 0 goes straight to readout
        stall = 1'b1;
        start(2'b10, 3'd0, 32'h0, 6'd0, 32'h6000);
        stall = 1'b0;
        repeat (6) step();
        chk("t4_armed", 64'(a_status), 64'd1);
        stall = 1'b1;
        step();
        stall = 1'b0;
        chk("t4_readout", 64'(a_status), 64'd3);
        drain(1'b0, 20);
        chk("t4_count", 64'(got_q.size()), 64'd7);
        if (got_q.size() == 7) begin
            chk("t4_first", 64'(fpc(got_q[0], 0)), 64'h6004);
            chk("t4_st0", 64'(got_q[0][EW-1]), 64'd0);
            chk("t4_trig_pc", 64'(fpc(got_q[6], 0)), 64'h601C);
            chk("t4_st6", 64'(got_q[6][EW-1]), 64'd1);
        end

        // any-stage match (only stage 4 hits), throttled readout
        start(2'b11, 3'd0, 32'h7000 - 32'd12, 6'd2, 32'h7000);
        step();
        chk("t5_post", 64'(a_status), 64'd2);
        step();
        step();
        chk("t5_readout", 64'(a_status), 64'd3);
        drain(1'b1, 20);
        chk("t5_count", 64'(got_q.size()), 64'd3);
        for (int k = 0; k < got_q.size(); k++)
            chk("t5_pc", 64'(fpc(got_q[k], 0)), 64'(32'h7000 + 32'(4*(k+1))));

        // asynchronous reset in POST
        start(2'b00, 3'd0, 32'h0, 6'd10, 32'h8000);
        repeat (3) step();
        chk("t6_post", 64'(a_status), 64'd2);
        reset = 1'b0;
        #1;
        chk("t6_rst_status", 64'(a_status), 64'd0);
        chk("t6_rst_valid", 64'(a_valid), 64'd0);
        #1;
        reset = 1'b1;
        step();
        step();
        chk("t6_no_resume", 64'(a_status), 64'd0);

        // synchronous clear in READOUT
        start(2'b00, 3'd0, 32'h0, 6'd1, 32'h9000);
        step();
        step();
        chk("t7_readout", 64'(a_status), 64'd3);
        chk("t7_valid", 64'(a_valid), 64'd1);
        clear = 1'b1;
        rd_ready = 1'b0;
        #1;
        chk("t7_sync", 64'(a_status), 64'd3);
        step();
        clear = 1'b0;
        chk("t7_status", 64'(a_status), 64'd0);
        chk("t7_cvalid", 64'(a_valid), 64'd0);
        chk("t7_clast", 64'(a_last), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
